// File: rtl/reg_dump_pkg.sv
// rtl/reg_dump_pkg.sv - shared constants and FSM state type for the register dump unit
package reg_dump_pkg;

  localparam int RDU_NUM_REGS = 32;
  localparam int RDU_DATA_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_SEND   = 2'd2,
    ST_FINISH = 2'd3
  } rdu_state_e;

endpackage

// File: rtl/reg_dump_unit.sv
// rtl/reg_dump_unit.sv - walks a register file and streams every entry as a handshaked record
module reg_dump_unit
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = RDU_NUM_REGS,
  parameter int DATA_W   = RDU_DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        trigger,
  output logic [$clog2(NUM_REGS)-1:0] rf_addr,
  input  logic [DATA_W-1:0]           rf_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(NUM_REGS)-1:0] out_index,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_last,
  output logic                        busy,
  output logic                        dump_done
);

  localparam int                IDX_W    = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REGS - 1);

  rdu_state_e         state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  out_data_q;

  // Dump sequencer: index and state advance together so the record never outruns its address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      out_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          idx_q <= '0;
          if (trigger) begin
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // Snapshot the entry here so later register-file changes cannot disturb a stalled record
          out_data_q <= rf_data;
          state_q    <= ST_SEND;
        end
        ST_SEND: begin
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q <= ST_FINISH;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= ST_FETCH;
            end
          end
        end
        ST_FINISH: begin
          idx_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  // Outputs are pure decodes of state and index, so none of them combinationally follows out_ready
  assign rf_addr   = idx_q;
  assign out_index = idx_q;
  assign out_data  = out_data_q;
  assign out_valid = (state_q == ST_SEND);
  assign out_last  = (state_q == ST_SEND) && (idx_q == LAST_IDX);
  assign busy      = (state_q != ST_IDLE);
  assign dump_done = (state_q == ST_FINISH);

endmodule
